id_hazard: RTL and testbench

Instruction-decode stage of the 5-stage RV32I hazard pipeline; consumes the IF/ID register outputs of the fetch stage.
- Decodes the instruction, reads a 32x32 register file (written back from WB) and generates the immediate.
- Detects load-use hazards: drives PCWrite/Write_IFID back to fetch and injects a bubble.
- Owns and registers the ID/EX pipeline register.

---
 rtl/riscv_pkg.sv | 55 +++++
 rtl/register_file.sv | 50 +++++
 rtl/id_hazard.sv | 191 +++++++++++++++++++
 tb/tb_id_hazard.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the RV32I hazard pipeline.
//   XLEN            datapath width
//   OP_*            major opcodes decoded in ID
//   RESULT_*        ResultSrc encodings (ALU / memory / PC+4)
//   ALUOP_*         ALUOp encodings handed to the EX-stage ALU decoder
//   ctrl_t, idex_t  ID/EX pipeline register layout
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LUI   = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t           ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
  } idex_t;

endpackage

// File: rtl/register_file.sv
// register_file: NREG x XLEN architectural registers, x0 hardwired to zero.
//   clk, rst_n   clock, async active-low reset (clears all entries)
//   we, wa, wd   write port (from WB); writes to x0 are dropped
//   ra1/rd1, ra2/rd2  two asynchronous read ports
// Optional macro RF_BYPASS_EN: a read of the register being written this
// cycle returns the write data (write-through); otherwise the old value.
module register_file
  import riscv_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic            wr_en;

  assign wr_en = we && (wa != 5'd0);

  always_comb begin
    rf_d = rf_q;
    if (wr_en) rf_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

`ifdef RF_BYPASS_EN
  assign rd1 = (ra1 == 5'd0) ? '0 : (wr_en && wa == ra1) ? wd : rf_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : (wr_en && wa == ra2) ? wd : rf_q[ra2];
`else
  assign rd1 = (ra1 == 5'd0) ? '0 : rf_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : rf_q[ra2];
`endif

endmodule

// File: rtl/id_hazard.sv
// id_hazard: RV32I instruction-decode stage with load-use hazard detection.
//   clk, rst_n                 clock, async active-low reset
//   Instruc/PC/PC_plus4_IFID   instruction and PCs from IF/ID
//   flush_ID                   taken branch/jump in EX: kill ID contents
//   RegWrite_WB/rd_WB/Result_WB  register-file write-back port
//   PCWrite, Write_IFID        0 = fetch holds (load-use stall)
//   *_IDEX                     registered ID/EX pipeline outputs
// Optional macro RF_BYPASS_EN (see register_file): WB write-through on reads.
module id_hazard
  import riscv_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] Instruc_IFID,
  input  logic [XLEN-1:0] PC_IFID,
  input  logic [XLEN-1:0] PC_plus4_IFID,
  input  logic            flush_ID,
  input  logic            RegWrite_WB,
  input  logic [4:0]      rd_WB,
  input  logic [XLEN-1:0] Result_WB,
  output logic            PCWrite,
  output logic            Write_IFID,
  output logic [XLEN-1:0] RD1_IDEX,
  output logic [XLEN-1:0] RD2_IDEX,
  output logic [XLEN-1:0] Imm_IDEX,
  output logic [XLEN-1:0] PC_IDEX,
  output logic [XLEN-1:0] PC_plus4_IDEX,
  output logic [4:0]      rs1_IDEX,
  output logic [4:0]      rs2_IDEX,
  output logic [4:0]      rd_IDEX,
  output logic [2:0]      funct3_IDEX,
  output logic            funct7b5_IDEX,
  output logic            RegWrite_IDEX,
  output logic            MemRead_IDEX,
  output logic            MemWrite_IDEX,
  output logic            ALUSrc_IDEX,
  output logic            Branch_IDEX,
  output logic            Jump_IDEX,
  output logic [1:0]      ResultSrc_IDEX,
  output logic [1:0]      ALUOp_IDEX
);

  logic [31:0]     ins;
  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  ctrl_t           ctrl;
  logic [XLEN-1:0] imm, rd1, rd2;
  logic            rs1_used, rs2_used, hz;
  idex_t           idex_q, idex_d;

  assign ins    = Instruc_IFID;
  assign opcode = ins[6:0];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];
  assign rd     = ins[11:7];

  register_file #(.NREG(NREG)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (RegWrite_WB),
    .wa    (rd_WB),
    .wd    (Result_WB),
    .ra1   (rs1),
    .ra2   (rs2),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  // Control decode and immediate select; unknown opcodes decode as NOP.
  always_comb begin
    ctrl     = '0;
    imm      = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
        rs1_used       = 1'b1;
        imm            = {{(XLEN-12){ins[31]}}, ins[31:20]};
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RESULT_MEM;
        rs1_used        = 1'b1;
        imm             = {{(XLEN-12){ins[31]}}, ins[31:20]};
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
        imm            = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_BR;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        imm         = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RESULT_PC4;
        imm             = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RESULT_PC4;
        rs1_used        = 1'b1;
        imm             = {{(XLEN-12){ins[31]}}, ins[31:20]};
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_LUI;
        imm            = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm            = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  // Load in EX whose destination feeds an operand of the ID instruction.
  assign hz = idex_q.ctrl.mem_read && (idex_q.rd != 5'd0) &&
              ((rs1_used && idex_q.rd == rs1) || (rs2_used && idex_q.rd == rs2));

  // A flush discards the ID instruction anyway, so it must not freeze fetch.
  assign PCWrite    = !(hz && !flush_ID);
  assign Write_IFID = PCWrite;

  always_comb begin
    idex_d = '0;
    if (!flush_ID && !hz) begin
      idex_d.ctrl     = ctrl;
      idex_d.rd1      = rd1;
      idex_d.rd2      = rd2;
      idex_d.imm      = imm;
      idex_d.pc       = PC_IFID;
      idex_d.pc4      = PC_plus4_IFID;
      idex_d.rs1      = rs1;
      idex_d.rs2      = rs2;
      idex_d.rd       = rd;
      idex_d.funct3   = ins[14:12];
      idex_d.funct7b5 = ins[30];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign RD1_IDEX       = idex_q.rd1;
  assign RD2_IDEX       = idex_q.rd2;
  assign Imm_IDEX       = idex_q.imm;
  assign PC_IDEX        = idex_q.pc;
  assign PC_plus4_IDEX  = idex_q.pc4;
  assign rs1_IDEX       = idex_q.rs1;
  assign rs2_IDEX       = idex_q.rs2;
  assign rd_IDEX        = idex_q.rd;
  assign funct3_IDEX    = idex_q.funct3;
  assign funct7b5_IDEX  = idex_q.funct7b5;
  assign RegWrite_IDEX  = idex_q.ctrl.reg_write;
  assign MemRead_IDEX   = idex_q.ctrl.mem_read;
  assign MemWrite_IDEX  = idex_q.ctrl.mem_write;
  assign ALUSrc_IDEX    = idex_q.ctrl.alu_src;
  assign Branch_IDEX    = idex_q.ctrl.branch;
  assign Jump_IDEX      = idex_q.ctrl.jump;
  assign ResultSrc_IDEX = idex_q.ctrl.result_src;
  assign ALUOp_IDEX     = idex_q.ctrl.alu_op;

endmodule

// File: tb/tb_id_hazard.sv
// tb_id_hazard: scoreboard bench for id_hazard. Each driven ID cycle pushes
// the expected ID/EX contents; the monitor pops and compares after the edge.
module tb_id_hazard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Instruc_IFID, PC_IFID, PC_plus4_IFID;
  logic        flush_ID, RegWrite_WB;
  logic [4:0]  rd_WB;
  logic [31:0] Result_WB;
  logic        PCWrite, Write_IFID;
  logic [31:0] RD1_IDEX, RD2_IDEX, Imm_IDEX, PC_IDEX, PC_plus4_IDEX;
  logic [4:0]  rs1_IDEX, rs2_IDEX, rd_IDEX;
  logic [2:0]  funct3_IDEX;
  logic        funct7b5_IDEX;
  logic        RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, ALUSrc_IDEX, Branch_IDEX, Jump_IDEX;
  logic [1:0]  ResultSrc_IDEX, ALUOp_IDEX;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_hazard dut (
    .clk(clk), .rst_n(rst_n),
    .Instruc_IFID(Instruc_IFID), .PC_IFID(PC_IFID), .PC_plus4_IFID(PC_plus4_IFID),
    .flush_ID(flush_ID), .RegWrite_WB(RegWrite_WB), .rd_WB(rd_WB), .Result_WB(Result_WB),
    .PCWrite(PCWrite), .Write_IFID(Write_IFID),
    .RD1_IDEX(RD1_IDEX), .RD2_IDEX(RD2_IDEX), .Imm_IDEX(Imm_IDEX),
    .PC_IDEX(PC_IDEX), .PC_plus4_IDEX(PC_plus4_IDEX),
    .rs1_IDEX(rs1_IDEX), .rs2_IDEX(rs2_IDEX), .rd_IDEX(rd_IDEX),
    .funct3_IDEX(funct3_IDEX), .funct7b5_IDEX(funct7b5_IDEX),
    .RegWrite_IDEX(RegWrite_IDEX), .MemRead_IDEX(MemRead_IDEX), .MemWrite_IDEX(MemWrite_IDEX),
    .ALUSrc_IDEX(ALUSrc_IDEX), .Branch_IDEX(Branch_IDEX), .Jump_IDEX(Jump_IDEX),
    .ResultSrc_IDEX(ResultSrc_IDEX), .ALUOp_IDEX(ALUOp_IDEX)
  );

  // Control vector: {RegWrite, MemRead, MemWrite, Branch, Jump, ResultSrc, ALUOp}
  localparam logic [8:0] C_NONE = 9'b0_0_0_0_0_00_00;
  localparam logic [8:0] C_LOAD = 9'b1_1_0_0_0_01_00;
  localparam logic [8:0] C_R    = 9'b1_0_0_0_0_00_10;
  localparam logic [8:0] C_LUI  = 9'b1_0_0_0_0_00_11;
  localparam logic [8:0] C_BR   = 9'b0_0_0_1_0_00_01;
  localparam logic [8:0] C_JAL  = 9'b1_0_0_0_1_10_00;
  localparam logic [8:0] C_ST   = 9'b0_0_1_0_0_00_00;

  typedef struct {
    string       nm;
    logic [8:0]  ctl;
    logic [31:0] pc, pc4, d1, d2, imm;
    logic [4:0]  r1, r2, rd;
    bit          c_idx, c_data, c_imm, bubble;
  } exp_t;

  exp_t sb[$];
  logic [31:0] pc;

  function automatic exp_t mk(string nm, logic [8:0] ctl, logic [31:0] p,
                              logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                              logic [31:0] d1, logic [31:0] d2, logic [31:0] im,
                              bit ci, bit cd, bit cim);
    exp_t e;
    e.nm = nm; e.ctl = ctl; e.pc = p; e.pc4 = p + 32'd4;
    e.r1 = r1; e.r2 = r2; e.rd = rd; e.d1 = d1; e.d2 = d2; e.imm = im;
    e.c_idx = ci; e.c_data = cd; e.c_imm = cim; e.bubble = 1'b0;
    return e;
  endfunction

  function automatic exp_t bub(string nm);
    exp_t e;
    e = mk(nm, C_NONE, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1, 1, 1);
    e.pc4 = 32'd0;
    e.bubble = 1'b1;
    return e;
  endfunction

  function automatic exp_t nop(logic [31:0] p);
    return mk("nop", C_NONE, p, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [31:0] enc_add(logic [4:0] rd, logic [4:0] r1, logic [4:0] r2);
    return {7'b0, r2, r1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_lw(logic [4:0] rd, logic [4:0] r1);
    return {12'h000, r1, 3'b010, rd, 7'b0000011};
  endfunction

  // Scoreboard monitor: one expectation per clocked ID cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, Branch_IDEX, Jump_IDEX,
           ResultSrc_IDEX, ALUOp_IDEX} !== e.ctl) begin
        errors++;
        $display("FAIL %s ctrl: got %b want %b", e.nm,
                 {RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, Branch_IDEX, Jump_IDEX,
                  ResultSrc_IDEX, ALUOp_IDEX}, e.ctl);
      end
      checks++;
      if ({PC_IDEX, PC_plus4_IDEX} !== {e.pc, e.pc4}) begin
        errors++;
        $display("FAIL %s pc: got %h/%h want %h/%h", e.nm, PC_IDEX, PC_plus4_IDEX, e.pc, e.pc4);
      end
      if (e.c_idx) begin
        checks++;
        if ({rs1_IDEX, rs2_IDEX, rd_IDEX} !== {e.r1, e.r2, e.rd}) begin
          errors++;
          $display("FAIL %s idx: got %0d,%0d,%0d want %0d,%0d,%0d", e.nm,
                   rs1_IDEX, rs2_IDEX, rd_IDEX, e.r1, e.r2, e.rd);
        end
      end
      if (e.c_data) begin
        checks++;
        if ({RD1_IDEX, RD2_IDEX} !== {e.d1, e.d2}) begin
          errors++;
          $display("FAIL %s data: got %h,%h want %h,%h", e.nm, RD1_IDEX, RD2_IDEX, e.d1, e.d2);
        end
      end
      if (e.c_imm) begin
        checks++;
        if (Imm_IDEX !== e.imm) begin
          errors++;
          $display("FAIL %s imm: got %h want %h", e.nm, Imm_IDEX, e.imm);
        end
      end
      if (e.bubble) begin
        checks++;
        if ({ALUSrc_IDEX, funct3_IDEX, funct7b5_IDEX} !== 5'b0) begin
          errors++;
          $display("FAIL %s bubble extra: got %b want 00000", e.nm,
                   {ALUSrc_IDEX, funct3_IDEX, funct7b5_IDEX});
        end
      end
    end
  end

  task automatic drive(input logic [31:0] ins, input logic fl, input logic wbe,
                       input logic [4:0] wrd, input logic [31:0] wdat, input exp_t e);
    @(negedge clk);
    Instruc_IFID = ins; PC_IFID = pc; PC_plus4_IFID = pc + 32'd4;
    flush_ID = fl; RegWrite_WB = wbe; rd_WB = wrd; Result_WB = wdat;
    sb.push_back(e);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
    drive(32'h0, 0, 1, r, v, nop(pc));
    pc += 4;
  endtask

  task automatic test_setup;
    wb_write(5'd1, 32'h0000_0100);
    wb_write(5'd2, 32'h0000_0022);
    wb_write(5'd5, 32'h0000_0055);
    wb_write(5'd7, 32'h1111_1111);
  endtask

  task automatic test_reset;
    drive(enc_lw(5, 1), 0, 0, 0, 0,
          mk("pre_rst_lw", C_LOAD, pc, 1, 0, 5, 32'h100, 0, 0, 1, 1, 1));
    pc += 4;
    @(negedge clk);
    rst_n = 1'b0;
    Instruc_IFID = 32'h0; RegWrite_WB = 1'b0;
    #1;
    checks++;
    if ({RD1_IDEX, RD2_IDEX, Imm_IDEX, PC_IDEX, PC_plus4_IDEX, rs1_IDEX, rs2_IDEX, rd_IDEX,
         funct3_IDEX, funct7b5_IDEX, RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, ALUSrc_IDEX,
         Branch_IDEX, Jump_IDEX, ResultSrc_IDEX, ALUOp_IDEX} !== '0) begin
      errors++;
      $display("FAIL reset_idex: got nonzero ID/EX (rd_IDEX=%0d MemRead=%b) want all 0",
               rd_IDEX, MemRead_IDEX);
    end
    checks++;
    if ({PCWrite, Write_IFID} !== 2'b11) begin
      errors++;
      $display("FAIL reset_fetch_en: got %b want 11", {PCWrite, Write_IFID});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      drive(enc_add(6, i[4:0], i[4:0]), 0, 0, 0, 0,
            mk("rf_cleared", C_R, pc, i[4:0], i[4:0], 6, 0, 0, 0, 1, 1, 0));
      pc += 4;
    end
  endtask

  task automatic test_load_use;
    drive(enc_lw(5, 1), 0, 0, 0, 0, mk("lu_lw", C_LOAD, pc, 1, 0, 5, 32'h100, 0, 0, 1, 1, 1));
    pc += 4;
    drive(enc_add(6, 5, 2), 0, 0, 0, 0, bub("lu_bubble"));
    checks++;
    if ({PCWrite, Write_IFID} !== 2'b00) begin
      errors++;
      $display("FAIL lu_stall: got %b want 00", {PCWrite, Write_IFID});
    end
    drive(enc_add(6, 5, 2), 0, 0, 0, 0,
          mk("lu_add", C_R, pc, 5, 2, 6, 32'h55, 32'h22, 0, 1, 1, 0));
    checks++;
    if ({PCWrite, Write_IFID} !== 2'b11) begin
      errors++;
      $display("FAIL lu_release: got %b want 11", {PCWrite, Write_IFID});
    end
    pc += 4;
  endtask

  task automatic test_no_stall;
    drive(enc_lw(0, 1), 0, 0, 0, 0, mk("x0_lw", C_LOAD, pc, 1, 0, 0, 32'h100, 0, 0, 1, 1, 1));
    pc += 4;
    drive(enc_add(6, 0, 2), 0, 0, 0, 0, mk("x0_add", C_R, pc, 0, 2, 6, 0, 32'h22, 0, 1, 1, 0));
    checks++;
    if (PCWrite !== 1'b1) begin
      errors++;
      $display("FAIL x0_nostall: got %b want 1", PCWrite);
    end
    pc += 4;
    drive(enc_lw(5, 1), 0, 0, 0, 0, mk("lui_lw", C_LOAD, pc, 1, 0, 5, 32'h100, 0, 0, 1, 1, 1));
    pc += 4;
    drive({20'h12345, 5'd5, 7'b0110111}, 0, 0, 0, 0,
          mk("lui", C_LUI, pc, 0, 0, 0, 0, 0, 32'h1234_5000, 0, 0, 1));
    checks++;
    if (PCWrite !== 1'b1) begin
      errors++;
      $display("FAIL lui_nostall: got %b want 1", PCWrite);
    end
    pc += 4;
  endtask

  task automatic test_flush;
    drive(enc_lw(5, 1), 0, 0, 0, 0, mk("fl_lw", C_LOAD, pc, 1, 0, 5, 32'h100, 0, 0, 1, 1, 1));
    pc += 4;
    drive(enc_add(6, 5, 2), 1, 0, 0, 0, bub("fl_bubble"));
    checks++;
    if ({PCWrite, Write_IFID} !== 2'b11) begin
      errors++;
      $display("FAIL flush_nostall: got %b want 11", {PCWrite, Write_IFID});
    end
    pc += 4;
    drive(32'h0, 0, 0, 0, 0, nop(pc));
    pc += 4;
  endtask

  task automatic test_bypass;
    logic [31:0] first;
`ifdef RF_BYPASS_EN
    first = 32'hDEAD_BEEF;
`else
    first = 32'h1111_1111;
`endif
    drive(enc_add(8, 7, 7), 0, 1, 7, 32'hDEAD_BEEF,
          mk("byp_same", C_R, pc, 7, 7, 8, first, first, 0, 1, 1, 0));
    pc += 4;
    drive(enc_add(8, 7, 7), 0, 0, 0, 0,
          mk("byp_reread", C_R, pc, 7, 7, 8, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1, 1, 0));
    pc += 4;
  endtask

  task automatic test_imm;
    drive(32'hFE20_8EE3, 0, 0, 0, 0,
          mk("beq", C_BR, pc, 1, 2, 0, 32'h100, 32'h22, 32'hFFFF_FFFC, 0, 1, 1));
    pc += 4;
    drive(32'h0010_00EF, 0, 0, 0, 0, mk("jal", C_JAL, pc, 0, 0, 0, 0, 0, 32'h800, 0, 0, 1));
    pc += 4;
    drive({7'h7F, 5'd2, 5'd1, 3'b010, 5'h18, 7'b0100011}, 0, 0, 0, 0,
          mk("sw", C_ST, pc, 1, 2, 0, 32'h100, 32'h22, 32'hFFFF_FFF8, 0, 1, 1));
    pc += 4;
  endtask

  task automatic test_back_to_back;
    drive(enc_lw(5, 1), 0, 0, 0, 0, mk("b2b_lw5", C_LOAD, pc, 1, 0, 5, 32'h100, 0, 0, 1, 1, 1));
    pc += 4;
    drive(enc_lw(9, 5), 0, 0, 0, 0, bub("b2b_bub1"));
    checks++;
    if (PCWrite !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall1: got %b want 0", PCWrite);
    end
    drive(enc_lw(9, 5), 0, 0, 0, 0, mk("b2b_lw9", C_LOAD, pc, 5, 0, 9, 32'h55, 0, 0, 1, 1, 1));
    pc += 4;
    // dependency through rs2 only
    drive(enc_add(10, 0, 9), 0, 0, 0, 0, bub("b2b_bub2"));
    checks++;
    if (PCWrite !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall2: got %b want 0", PCWrite);
    end
    drive(enc_add(10, 0, 9), 0, 0, 0, 0, mk("b2b_add", C_R, pc, 0, 9, 10, 0, 0, 0, 1, 1, 0));
    checks++;
    if (PCWrite !== 1'b1) begin
      errors++;
      $display("FAIL b2b_release: got %b want 1", PCWrite);
    end
    pc += 4;
  endtask

  initial begin
    rst_n = 1'b0;
    Instruc_IFID = '0; PC_IFID = '0; PC_plus4_IFID = '0;
    flush_ID = 1'b0; RegWrite_WB = 1'b0; rd_WB = '0; Result_WB = '0;
    pc = 32'h0000_1000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_setup();
    test_reset();
    test_setup();
    test_load_use();
    test_no_stall();
    test_flush();
    test_bypass();
    test_imm();
    test_back_to_back();
    drive(32'h0, 0, 0, 0, 0, nop(pc));
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
